// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Instruction word and address width
  localparam int WORD_W = 24;

  // One queue entry holds the address and the instruction word
  localparam int ENTRY_W = 2 * WORD_W;

  // Fetch address used after reset unless overridden
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 24'h000000;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_WAIT = 2'd1,  // request outstanding, data will be queued
    ST_DROP = 2'd2   // request outstanding, data will be discarded
  } fetch_state_t;

  // Queue entry layout: address in the upper half, instruction in the lower
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with flush, used as the fetch queue.
//               The head entry is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Flush wins over both ports; over/underflow requests are dropped defensively
  assign w_do_push = i_push && !i_flush && (r_count != CNT_FULL);
  assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array: written on push only, contents need no reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Issues one memory read at a
//               time, queues returned words with their addresses and
//               restarts the stream on redirect, discarding in-flight data.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [WORD_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [WORD_W-1:0]      mem_rdata,
  input  logic                   redirect,
  input  logic [WORD_W-1:0]      redirect_pc,
  output logic                   out_valid,
  output logic [WORD_W-1:0]      out_instr,
  output logic [WORD_W-1:0]      out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [WORD_W-1:0] r_fetch_pc;
  logic [WORD_W-1:0] r_mem_addr;
  logic              r_rst_done;

  logic              w_start;
  logic              w_push;
  logic              w_pop;
  logic              w_has_room;

  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;
  logic              w_fifo_valid;
  logic [CNT_W-1:0]  w_count;

  assign w_has_room = (w_count < CNT_FULL);

  // A redirect flushes the queue, so the consumer's accept is ignored then
  assign w_pop = w_fifo_valid && out_ready && !redirect;

  assign w_push_entry.pc    = r_fetch_pc;
  assign w_push_entry.instr = mem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign out_valid = w_fifo_valid;
  // Data outputs read as zero whenever the queue is empty (including reset)
  assign out_instr = w_fifo_valid ? w_head.instr : '0;
  assign out_pc    = w_fifo_valid ? w_head.pc    : '0;
  assign count     = w_count;
  assign mem_addr  = r_mem_addr;

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, request and push decode
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_push       = 1'b0;
    mem_req      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_rst_done holds off the first request by one cycle after reset
        if (!redirect && r_rst_done && w_has_room) begin
          w_next_state = ST_WAIT;
          w_start      = 1'b1;
        end
      end
      ST_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          // Data returning alongside a redirect belongs to the old stream
          w_push       = !redirect;
          w_next_state = ST_IDLE;
        end else if (redirect) begin
          w_next_state = ST_DROP;
        end
      end
      ST_DROP: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Fetch PC, latched request address and post-reset holdoff flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 24'd1;
      end
      if (w_start) begin
        r_mem_addr <= r_fetch_pc;
      end
    end
  end

endmodule
`default_nettype wire
